// File: rtl/msu_data_fetch.sv
// MSU-1 data port responder: prefetches 16-bit memory words into a byte ring buffer.
// Build option MSU_DATA_SIZE_CLAMP_EN adds data_size and returns 8'h00 past end of file.
//
// state   | meaning
// IDLE    | no memory transaction; start a word fetch once a seek was seen and room exists
// REQ     | mem_req held high until mem_ack; data dropped when a seek arrived meanwhile
module msu_data_fetch #(
  parameter int BUF_DEPTH = 16,
  parameter int ADDR_W    = 32
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic [31:0]       msu_data_addr,
  input  logic              msu_data_seek,
  input  logic              msu_data_req,
  output logic [7:0]        msu_data_out,
  output logic              msu_data_busy,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [15:0]       mem_rdata
`ifdef MSU_DATA_SIZE_CLAMP_EN
  ,
  input  logic [ADDR_W-1:0] data_size
`endif
);

  localparam int IW = $clog2(BUF_DEPTH);
  localparam int PW = IW + 1;

  typedef enum logic {ST_IDLE, ST_REQ} state_t;

  state_t            state, state_nxt;
  logic [PW-1:0]     wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt;
  logic [PW-1:0]     count, count_nxt;
  logic [7:0]        buf_mem [BUF_DEPTH];
  logic [ADDR_W-1:0] fetch_addr, fetch_addr_nxt;
  logic              seeked, seeked_nxt;
  logic              stale;
  logic              ack_take, clamp_fill, pop;
  logic              we0, we1;
  logic [7:0]        wd0, wd1;
  logic [1:0]        n_wr;
  logic [IW-1:0]     wi0, wi1, ri_nxt;
  logic [7:0]        rd_byte_nxt;
  logic              past_end, hi_past_end;

`ifdef MSU_DATA_SIZE_CLAMP_EN
  assign past_end    = (fetch_addr >= data_size);
  assign hi_past_end = ({fetch_addr[ADDR_W-1:1], 1'b1} >= data_size);
`else
  assign past_end    = 1'b0;
  assign hi_past_end = 1'b0;
`endif

  assign count = wr_ptr - rd_ptr;
  assign wi0   = wr_ptr[IW-1:0];
  assign wi1   = wi0 + IW'(1);

  // Buffer write/read pointer bookkeeping for this cycle.
  always_comb begin
    ack_take   = (state == ST_REQ) && mem_ack && !stale && !msu_data_seek;
    clamp_fill = (state == ST_IDLE) && seeked && !msu_data_seek && past_end &&
                 (count != PW'(BUF_DEPTH));
    we0  = 1'b0;
    we1  = 1'b0;
    wd0  = mem_rdata[7:0];
    wd1  = mem_rdata[15:8];
    n_wr = 2'd0;
    if (ack_take) begin
      if (fetch_addr[0]) begin
        we0  = 1'b1;
        wd0  = mem_rdata[15:8];
        n_wr = 2'd1;
      end else begin
        we0  = 1'b1;
        we1  = 1'b1;
        n_wr = 2'd2;
        if (hi_past_end) wd1 = 8'h00;
      end
    end else if (clamp_fill) begin
      we0  = 1'b1;
      wd0  = 8'h00;
      n_wr = 2'd1;
    end

    pop        = msu_data_req && !msu_data_seek && (count != '0);
    wr_ptr_nxt = wr_ptr + PW'(n_wr);
    rd_ptr_nxt = msu_data_seek ? wr_ptr : rd_ptr + PW'(pop);
    count_nxt  = wr_ptr_nxt - rd_ptr_nxt;
    seeked_nxt = seeked | msu_data_seek;

    if (msu_data_seek)   fetch_addr_nxt = ADDR_W'(msu_data_addr);
    else if (ack_take)   fetch_addr_nxt = (fetch_addr | ADDR_W'(1)) + ADDR_W'(1);
    else if (clamp_fill) fetch_addr_nxt = fetch_addr + ADDR_W'(1);
    else                 fetch_addr_nxt = fetch_addr;
  end

  // The next head byte may be the one being written this very cycle.
  always_comb begin
    ri_nxt = rd_ptr_nxt[IW-1:0];
    if (we0 && (ri_nxt == wi0))      rd_byte_nxt = wd0;
    else if (we1 && (ri_nxt == wi1)) rd_byte_nxt = wd1;
    else                             rd_byte_nxt = buf_mem[ri_nxt];
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (seeked && !msu_data_seek && !past_end && (count <= PW'(BUF_DEPTH - 2)))
          state_nxt = ST_REQ;
      end
      ST_REQ: begin
        if (mem_ack) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    mem_req = (state == ST_REQ);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      fetch_addr    <= '0;
      seeked        <= 1'b0;
      stale         <= 1'b0;
      mem_addr      <= '0;
      msu_data_out  <= 8'h00;
      msu_data_busy <= 1'b0;
    end else begin
      wr_ptr     <= wr_ptr_nxt;
      rd_ptr     <= rd_ptr_nxt;
      fetch_addr <= fetch_addr_nxt;
      seeked     <= seeked_nxt;
      // A transaction in flight cannot be cancelled, so its data is marked for discard.
      if ((state == ST_REQ) && mem_ack)            stale <= 1'b0;
      else if ((state == ST_REQ) && msu_data_seek) stale <= 1'b1;
      if ((state == ST_IDLE) && (state_nxt == ST_REQ))
        mem_addr <= {fetch_addr[ADDR_W-1:1], 1'b0};
      if (count_nxt != '0) msu_data_out <= rd_byte_nxt;
      msu_data_busy <= seeked_nxt && (count_nxt == '0);
    end
  end

  always_ff @(posedge CLK) begin
    if (we0) buf_mem[wi0] <= wd0;
    if (we1) buf_mem[wi1] <= wd1;
  end

endmodule

// File: tb/tb_msu_data_fetch.sv
// Bench for msu_data_fetch: byte-stream reference model plus a randomized-latency memory.
// Define MSU_DATA_SIZE_CLAMP_EN to also exercise the end-of-file clamp.
`timescale 1ns/1ps
module tb_msu_data_fetch;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic [31:0] msu_data_addr = '0;
  logic        msu_data_seek = 1'b0;
  logic        msu_data_req = 1'b0;
  logic [7:0]  msu_data_out;
  logic        msu_data_busy;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack = 1'b0;
  logic [15:0] mem_rdata = '0;
`ifdef MSU_DATA_SIZE_CLAMP_EN
  logic [31:0] data_size = 32'hFFFF_FFFF;
`endif

  int          n_checks = 0;
  int          n_errors = 0;
  int          forced_lat = 0;
  logic [31:0] req_log[$];
  logic [7:0]  ovr [logic [31:0]];
  logic [31:0] m_cur = '0;
  bit          mem_pending = 0;
  int          mem_lat = 0;
  logic [31:0] mem_held = '0;

  always #5 CLK = ~CLK;

  msu_data_fetch #(.BUF_DEPTH(16), .ADDR_W(32)) dut (
    .CLK(CLK),
    .RST_N(RST_N),
    .msu_data_addr(msu_data_addr),
    .msu_data_seek(msu_data_seek),
    .msu_data_req(msu_data_req),
    .msu_data_out(msu_data_out),
    .msu_data_busy(msu_data_busy),
    .mem_req(mem_req),
    .mem_addr(mem_addr),
    .mem_ack(mem_ack),
`ifdef MSU_DATA_SIZE_CLAMP_EN
    .data_size(data_size),
`endif
    .mem_rdata(mem_rdata)
  );

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] raw_byte(input logic [31:0] a);
    if (ovr.exists(a)) return ovr[a];
    return a[7:0] ^ a[15:8] ^ a[23:16] ^ a[31:24] ^ 8'h3C;
  endfunction

  function automatic logic [7:0] exp_byte(input logic [31:0] a);
`ifdef MSU_DATA_SIZE_CLAMP_EN
    if (a >= data_size) return 8'h00;
`endif
    return raw_byte(a);
  endfunction

  // Memory: one outstanding read, latency forced or random, protocol checked each cycle.
  initial begin
    forever begin
      @(negedge CLK);
      mem_ack = 1'b0;
      if (!RST_N) begin
        mem_pending = 0;
        continue;
      end
      if (mem_pending) begin
        chk_eq("mem_req_held", {31'b0, mem_req}, 32'd1);
        chk_eq("mem_addr_held", mem_addr, mem_held);
      end else if (mem_req) begin
        mem_pending = 1;
        mem_held = mem_addr;
        req_log.push_back(mem_addr);
        mem_lat = (forced_lat >= 0) ? forced_lat : int'($urandom_range(0, 3));
        chk_eq("mem_addr_even", {31'b0, mem_addr[0]}, 32'd0);
      end
      if (mem_pending) begin
        if (mem_lat == 0) begin
          mem_ack = 1'b1;
          mem_rdata = {raw_byte(mem_held + 32'd1), raw_byte(mem_held)};
          mem_pending = 0;
        end else begin
          mem_lat--;
        end
      end
    end
  end

  task automatic cyc();
    @(negedge CLK);
    msu_data_seek = 1'b0;
    msu_data_req = 1'b0;
  endtask

  task automatic settle(input int n);
    repeat (n) cyc();
  endtask

  task automatic do_seek(input logic [31:0] a);
    msu_data_addr = a;
    msu_data_seek = 1'b1;
    cyc();
    m_cur = a;
    chk_eq("busy_after_seek", {31'b0, msu_data_busy}, 32'd1);
  endtask

  task automatic do_req();
    msu_data_req = 1'b1;
    if (!msu_data_busy) m_cur = m_cur + 32'd1;
    cyc();
  endtask

  task automatic chk_out(input string tag);
    chk_eq(tag, {24'b0, msu_data_out}, {24'b0, exp_byte(m_cur)});
  endtask

  task automatic wait_ready(input int max, input string tag);
    for (int k = 0; k < max && msu_data_busy; k++) cyc();
    chk_eq(tag, {31'b0, msu_data_busy}, 32'd0);
  endtask

  initial begin
    int base;
    int idle_busy;
    int r;
    logic [31:0] a;

    ovr[32'h100] = 8'hAA; ovr[32'h101] = 8'hBB; ovr[32'h102] = 8'hCC; ovr[32'h103] = 8'hDD;
    ovr[32'h200] = 8'h11; ovr[32'h201] = 8'h22;
    ovr[32'h400] = 8'h5E;
    ovr[32'h1000] = 8'h66; ovr[32'h2000] = 8'h77;
    ovr[32'h2FE] = 8'hA1; ovr[32'h2FF] = 8'hA2; ovr[32'h300] = 8'hA3;
    ovr[32'h301] = 8'hA4; ovr[32'h302] = 8'hA5; ovr[32'h303] = 8'hA6;

    repeat (3) @(negedge CLK);
    chk_eq("rst_out", {24'b0, msu_data_out}, 32'h0);
    chk_eq("rst_busy", {31'b0, msu_data_busy}, 32'h0);
    chk_eq("rst_mem_req", {31'b0, mem_req}, 32'h0);
    chk_eq("rst_mem_addr", mem_addr, 32'h0);
    RST_N = 1'b1;
    settle(5);
    chk_eq("no_fetch_before_seek", req_log.size(), 32'd0);
    chk_eq("busy_before_seek", {31'b0, msu_data_busy}, 32'h0);

    // Even seek, bytes consumed back to back including the word arriving that cycle.
    forced_lat = 0;
    do_seek(32'h100);
    base = req_log.size();
    wait_ready(50, "t1_ready");
    chk_eq("t1_first_addr", req_log[base], 32'h100);
    chk_eq("t1_b0", {24'b0, msu_data_out}, 32'hAA);
    do_req(); chk_eq("t1_b1", {24'b0, msu_data_out}, 32'hBB);
    do_req(); chk_eq("t1_b2", {24'b0, msu_data_out}, 32'hCC);
    do_req(); chk_eq("t1_b3", {24'b0, msu_data_out}, 32'hDD);
    chk_eq("t1_busy", {31'b0, msu_data_busy}, 32'h0);

    // Odd seek takes only the high byte of the first word.
    settle(40);
    do_seek(32'h201);
    base = req_log.size();
    wait_ready(50, "t2_ready");
    chk_eq("t2_first_addr", req_log[base], 32'h200);
    chk_eq("t2_out", {24'b0, msu_data_out}, 32'h22);
    for (int k = 0; k < 10 && req_log.size() <= base + 1; k++) cyc();
    chk_eq("t2_next_addr", req_log[base + 1], 32'h202);

    // Slow memory; a req while empty must be ignored.
    settle(40);
    forced_lat = 40;
    do_seek(32'h400);
    settle(5);
    do_req();
    chk_eq("t3_busy_hold", {31'b0, msu_data_busy}, 32'h1);
    settle(20);
    chk_eq("t3_busy_hold2", {31'b0, msu_data_busy}, 32'h1);
    wait_ready(80, "t3_ready");
    forced_lat = 0;
    chk_eq("t3_out", {24'b0, msu_data_out}, 32'h5E);
    chk_out("t3_model_out");

    // Reseek while a fetch is pending: old data discarded, single refetch.
    settle(60);
    forced_lat = 20;
    do_seek(32'h1000);
    base = req_log.size();
    for (int k = 0; k < 10 && req_log.size() <= base; k++) cyc();
    chk_eq("t4_first_addr", req_log[base], 32'h1000);
    settle(5);
    do_seek(32'h2000);
    wait_ready(100, "t4_ready");
    forced_lat = 0;
    chk_eq("t4_out", {24'b0, msu_data_out}, 32'h77);
    chk_eq("t4_req_count", req_log.size() - base, 32'd2);
    chk_eq("t4_second_addr", req_log[base + 1], 32'h2000);

    // Fill to capacity, then release room one byte at a time.
    settle(40);
    do_seek(32'h3000);
    base = req_log.size();
    settle(40);
    chk_eq("t5_fills", req_log.size() - base, 32'd8);
    chk_eq("t5_req_idle", {31'b0, mem_req}, 32'h0);
    chk_out("t5_out0");
    do_req();
    settle(10);
    chk_eq("t5_no_fetch_15", req_log.size() - base, 32'd8);
    chk_eq("t5_req_idle_15", {31'b0, mem_req}, 32'h0);
    chk_out("t5_out1");
    do_req();
    settle(4);
    chk_eq("t5_fetch_14", req_log.size() - base, 32'd9);
    chk_eq("t5_next_addr", req_log[base + 8], 32'h3010);
    chk_out("t5_out2");

`ifdef MSU_DATA_SIZE_CLAMP_EN
    settle(40);
    data_size = 32'h301;
    do_seek(32'h2FE);
    base = req_log.size();
    settle(30);
    for (int k = 0; k < 10; k++) begin
      chk_eq("clamp_busy", {31'b0, msu_data_busy}, 32'h0);
      chk_out("clamp_out");
      do_req();
      cyc();
    end
    chk_eq("clamp_req_count", req_log.size() - base, 32'd2);
    for (int k = base; k < req_log.size(); k++)
      chk_eq("clamp_req_below_end", {31'b0, req_log[k] >= 32'h302}, 32'd0);
    settle(40);
    data_size = 32'hFFFF_FFFF;
`endif

    // Random seeks/reqs against the byte-stream model.
    forced_lat = -1;
    idle_busy = 0;
    for (int i = 0; i < 3000; i++) begin
      if (!msu_data_busy) begin
        chk_out("rnd_out");
        idle_busy = 0;
      end else begin
        idle_busy++;
        if (idle_busy > 60) begin
          chk_eq("rnd_busy_bound", {31'b0, msu_data_busy}, 32'h0);
          idle_busy = 0;
        end
      end
      r = int'($urandom_range(0, 99));
      if (r < 3) begin
        a = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF0 + 32'($urandom_range(0, 15))
                                        : ($urandom & 32'h000F_FFFF);
        msu_data_req = (r == 0);
        do_seek(a);
        idle_busy = 0;
      end else if (r < 55) begin
        do_req();
      end else begin
        cyc();
      end
    end
    settle(10);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
